// File: rtl/red_pitaya_freq_meter.sv
// Gated frequency meter and lock monitor for an asynchronous reference clock.
// Latency: count_o/valid_o 1 cycle after gate end, locked_o/lost_o 2 cycles; no backpressure.
// Backpressure: none, results are produced every gate regardless of the consumer.
module red_pitaya_freq_meter #(
    parameter int GATE_CYCLES = 1000000,
    parameter int CNT_W       = 32,
    parameter int LOCK_GATES  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_clk_i,
    input  logic [CNT_W-1:0] expected_i,
    input  logic [CNT_W-1:0] tol_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             lost_o,
    output logic             missing_o
);

    localparam int G_W    = $clog2(GATE_CYCLES);
    localparam int GOOD_W = $clog2(LOCK_GATES + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } st_t;

    logic              s1_q, s2_q, s3_q;
    logic [G_W-1:0]    g_q, g_d;
    logic [CNT_W-1:0]  e_q, e_d, e_next;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              missing_q, missing_d;
    logic              lost_q, lost_d;
    logic [GOOD_W-1:0] good_q, good_d;
    st_t               st_q, st_d;

    logic             rise;
    logic             term;
    logic [CNT_W-1:0] diff;
    logic             inrange;
    logic             last_good;

    assign rise = s2_q & ~s3_q;
    assign term = (g_q == G_W'(GATE_CYCLES - 1));

    // Absolute difference as max minus min, so it can never overflow.
    assign diff    = (count_q >= expected_i) ? (count_q - expected_i) : (expected_i - count_q);
    assign inrange = (diff <= tol_i);
    assign last_good = ((32'(good_q) + 32'd1) == 32'(LOCK_GATES));

    always_comb begin
        g_d       = term ? '0 : g_q + G_W'(1);
        e_next    = (rise && (e_q != '1)) ? e_q + CNT_W'(1) : e_q;
        e_d       = e_next;
        count_d   = count_q;
        missing_d = missing_q;
        valid_d   = term;
        // A rise in the terminal cycle is folded into the closing gate.
        if (term) begin
            e_d       = '0;
            count_d   = e_next;
            missing_d = (e_next == '0);
        end
    end

    always_comb begin
        st_d   = st_q;
        good_d = good_q;
        lost_d = 1'b0;
        if (valid_q) begin
            unique case (st_q)
                ST_UNLOCKED: begin
                    if (inrange) begin
                        if (LOCK_GATES == 1) begin
                            st_d = ST_LOCKED;
                        end else begin
                            st_d   = ST_ACQUIRE;
                            good_d = GOOD_W'(1);
                        end
                    end
                end
                ST_ACQUIRE: begin
                    if (!inrange) begin
                        st_d   = ST_UNLOCKED;
                        good_d = '0;
                    end else if (last_good) begin
                        st_d = ST_LOCKED;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!inrange) begin
                        st_d   = ST_UNLOCKED;
                        good_d = '0;
                        lost_d = 1'b1;
                    end
                end
                default: begin
                    st_d   = ST_UNLOCKED;
                    good_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            g_q       <= '0;
            e_q       <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            missing_q <= 1'b0;
            lost_q    <= 1'b0;
            good_q    <= '0;
            st_q      <= ST_UNLOCKED;
        end else begin
            s1_q      <= ext_clk_i;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            g_q       <= g_d;
            e_q       <= e_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            missing_q <= missing_d;
            lost_q    <= lost_d;
            good_q    <= good_d;
            st_q      <= st_d;
        end
    end

    assign count_o   = count_q;
    assign valid_o   = valid_q;
    assign missing_o = missing_q;
    assign lost_o    = lost_q;
    assign locked_o  = (st_q == ST_LOCKED);

endmodule

// File: tb/tb_red_pitaya_freq_meter.sv
// Bench for red_pitaya_freq_meter: a 32-bit and a 4-bit instance share stimulus and
// are checked every cycle against a waveform-level edge-count and lock-run model.
module tb_red_pitaya_freq_meter;

    localparam int GC   = 100;
    localparam int LG   = 3;
    localparam int MAXC = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext;
    logic [31:0] exp_v;
    logic [31:0] tol_v;

    logic [31:0] cnt0;
    logic        val0, lck0, lost0, mis0;
    logic [3:0]  cnt1;
    logic        val1, lck1, lost1, mis1;

    always #5 clk = ~clk;

    red_pitaya_freq_meter #(.GATE_CYCLES(GC), .CNT_W(32), .LOCK_GATES(LG)) dut (
        .clk(clk), .rst(rst), .ext_clk_i(ext), .expected_i(exp_v), .tol_i(tol_v),
        .count_o(cnt0), .valid_o(val0), .locked_o(lck0), .lost_o(lost0), .missing_o(mis0)
    );

    red_pitaya_freq_meter #(.GATE_CYCLES(GC), .CNT_W(4), .LOCK_GATES(LG)) dut_sat (
        .clk(clk), .rst(rst), .ext_clk_i(ext), .expected_i(exp_v[3:0]), .tol_i(tol_v[3:0]),
        .count_o(cnt1), .valid_o(val1), .locked_o(lck1), .lost_o(lost1), .missing_o(mis1)
    );

    bit xh [MAXC];
    bit rh [MAXC];
    int cyc  = 0;
    int pj   = -1;
    int sect = 0;
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d want %0d", nm, cyc, got, want);
        end
    endtask

    // Reference waveform as seen after reset: anything before the reset cycle reads as 0.
    function automatic bit xr(input int i, input int lr);
        return (i > lr && i >= 0) ? xh[i] : 1'b0;
    endfunction

    // Rising transitions of the reference whose synchronized rise lands in cycles n-GC..n-1.
    function automatic longint gcount(input int n, input int lr);
        longint s = 0;
        for (int m = n - GC; m < n; m++)
            if (xr(m - 2, lr) && !xr(m - 3, lr)) s++;
        return s;
    endfunction

    // Per-cycle model and comparison for both instances.
    int     lastr = -1;
    int     run [2];
    bit     lk  [2];
    bit     ls  [2];
    bit     mis [2];
    longint cm  [2];
    bit     vm, pend;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (rh[cyc-1]) begin
                lastr = cyc - 1;
                vm = 0; pend = 0;
                for (int i = 0; i < 2; i++) begin
                    run[i] = 0; lk[i] = 0; ls[i] = 0; mis[i] = 0; cm[i] = 0;
                end
            end else begin
                int j;
                j = cyc - lastr - 1;
                for (int i = 0; i < 2; i++) begin
                    bit newl;
                    ls[i] = 0;
                    if (pend) begin
                        newl  = (run[i] >= LG);
                        ls[i] = lk[i] && !newl;
                        lk[i] = newl;
                    end
                end
                pend = 0;
                vm = (j > 0) && (j % GC == 0);
                if (vm) begin
                    longint raw;
                    raw = gcount(cyc, lastr);
                    for (int i = 0; i < 2; i++) begin
                        longint mx, e, t, d;
                        mx = (i == 1) ? 64'd15 : 64'hFFFF_FFFF;
                        e  = (i == 1) ? longint'(exp_v & 32'hF) : longint'(exp_v);
                        t  = (i == 1) ? longint'(tol_v & 32'hF) : longint'(tol_v);
                        cm[i]  = (raw > mx) ? mx : raw;
                        mis[i] = (cm[i] == 0);
                        d = (cm[i] >= e) ? cm[i] - e : e - cm[i];
                        run[i] = (d <= t) ? run[i] + 1 : 0;
                    end
                    pend = 1;
                end
            end
            chk("count32",   cnt0,  cm[0]);
            chk("valid32",   val0,  vm);
            chk("locked32",  lck0,  lk[0]);
            chk("lost32",    lost0, ls[0]);
            chk("missing32", mis0,  mis[0]);
            chk("count4",    cnt1,  cm[1]);
            chk("valid4",    val1,  vm);
            chk("locked4",   lck1,  lk[1]);
            chk("lost4",     lost1, ls[1]);
            chk("missing4",  mis1,  mis[1]);
        end
    end

    // Hand-computed expectations for the directed sections.
    always @(negedge clk) begin
        if (sect == 1 && pj == 0) begin
            chk("rst_count", cnt0, 0);
            chk("rst_valid", val0, 0);
            chk("rst_missing", mis0, 0);
        end
        if (sect == 1 && pj == 100) begin
            chk("term_edge_valid", val0, 1);
            chk("term_edge_count32", cnt0, 1);
            chk("term_edge_count4", cnt1, 1);
        end
        if (sect == 1 && pj == 200) begin
            chk("no_double_count", cnt0, 0);
            chk("no_double_missing", mis0, 1);
        end
        if (sect == 2 && pj == 500) chk("lock_not_yet", lck0, 0);
        if (sect == 2 && pj == 501) chk("lock_after_3rd", lck0, 1);
        if (sect == 2 && pj == 600) chk("nominal_count", cnt0, 10);
        if (sect == 3 && pj == 800) begin
            chk("loss_count", cnt0, 5);
            chk("loss_still_locked", lck0, 1);
        end
        if (sect == 3 && pj == 801) begin
            chk("loss_lost_pulse", lost0, 1);
            chk("loss_unlocked", lck0, 0);
        end
        if (sect == 3 && pj == 802) chk("loss_lost_single", lost0, 0);
        if (sect == 4 && pj == 1100) begin
            chk("missing_flag", mis0, 1);
            chk("missing_count", cnt0, 0);
            chk("missing_unlocked", lck0, 0);
        end
        if (sect == 5 && pj == 1849) chk("relock_before_rst", lck0, 1);
        if (sect == 6 && pj == 0) begin
            chk("midrst_locked", lck0, 0);
            chk("midrst_lost", lost0, 0);
            chk("midrst_count", cnt0, 0);
            chk("midrst_valid", val0, 0);
        end
        if (sect == 6 && pj == 99)  chk("midrst_no_early_valid", val0, 0);
        if (sect == 6 && pj == 100) chk("midrst_first_valid", val0, 1);
        if (sect == 6 && pj == 300) chk("midrst_relock_wait", lck0, 0);
        if (sect == 6 && pj == 301) chk("midrst_relock", lck0, 1);
        if (sect == 7 && pj == 600) begin
            chk("sat_count4", cnt1, 15);
            chk("sat_count32", cnt0, 25);
        end
    end

    task automatic step(input bit r, input bit x);
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        rst = r;
        ext = x;
        xh[cyc] = x;
        rh[cyc] = r;
        pj = r ? -1 : pj + 1;
    endtask

    task automatic wave(input int per, input int n, input int ph);
        for (int c = 0; c < n; c++)
            step(1'b0, (per == 0) ? 1'b0 : (((c + ph) % per) < per / 2));
    endtask

    initial begin
        rst = 1'b1;
        ext = 1'b0;
        exp_v = 32'd10;
        tol_v = 32'd1;
        xh[0] = 1'b0;
        rh[0] = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        sect = 1;
        for (int j = 0; j <= 201; j++) step(1'b0, (j == 97) || (j == 98));
        sect = 2;
        wave(10, 499, 1);
        sect = 3;
        wave(20, 300, 0);
        sect = 4;
        wave(0, 300, 0);
        sect = 5;
        wave(10, 549, 0);
        step(1'b1, 1'b0);
        sect = 6;
        wave(10, 450, 0);
        sect = 7;
        exp_v = 32'd25;
        wave(4, 300, 0);

        sect = 8;
        for (int k = 0; k < 30; k++) begin
            int per, ph, len, e;
            per = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(4, 30);
            ph  = (per == 0) ? 0 : $urandom_range(0, per - 1);
            len = $urandom_range(40, 250);
            e   = (per == 0) ? 0 : GC / per;
            e   = e + $urandom_range(0, 2) - 1;
            if (e < 0) e = 0;
            exp_v = 32'(e);
            tol_v = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) step(1'b1, 1'b0);
            wave(per, len, ph);
        end
        wave(10, 3 * GC, 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
